// File: rtl/gestor_int_prio_pkg.sv
// Shared definitions for the priority interrupt controller: FSM encoding,
// source count and source indices.
package gestor_int_prio_pkg;

  localparam int NSRC = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SVC  = 2'd2;

  localparam logic [1:0] SRC_TIMER = 2'd0;
  localparam logic [1:0] SRC_P2    = 2'd1;
  localparam logic [1:0] SRC_P3    = 2'd2;
  localparam logic [1:0] SRC_P4    = 2'd3;

  function automatic logic [NSRC-1:0] src_onehot(input logic [1:0] idx);
    return NSRC'(1) << idx;
  endfunction

endpackage

// File: rtl/gestor_int_prio_prio_enc4.sv
// Combinational 4-input fixed-priority encoder; bit 0 has the highest priority.
module prio_enc4
  import gestor_int_prio_pkg::*;
(
  input  logic [NSRC-1:0] i_req,
  output logic            o_valid,
  output logic [1:0]      o_idx
);

  always_comb begin
    o_idx = SRC_TIMER;
    if (i_req[0])      o_idx = SRC_TIMER;
    else if (i_req[1]) o_idx = SRC_P2;
    else if (i_req[2]) o_idx = SRC_P3;
    else if (i_req[3]) o_idx = SRC_P4;
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/gestor_int_prio.sv
// Priority interrupt controller: latches rising edges on four sources, masks,
// arbitrates by fixed priority and handshakes the PC redirect with the UC.
module gestor_int_prio
  import gestor_int_prio_pkg::*;
#(
  parameter int          PC_W       = 10,
  parameter int unsigned VEC_BASE   = 1008,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_in,
  input  logic            int_ack,
  input  logic            fin_int,
  output logic            int_req,
  output logic            pc_sel,
  output logic [PC_W-1:0] vector,
  output logic [1:0]      active_src,
  output logic            in_service,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);

  logic [1:0]      r_state;
  logic [NSRC-1:0] r_prev;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_mask;
  logic [1:0]      r_active_src;
  logic [PC_W-1:0] r_vector;

  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_elig;
  logic [NSRC-1:0] w_clr;
  logic            w_valid;
  logic [1:0]      w_idx;
  logic [PC_W-1:0] w_vec;
  logic            w_ack_take;

  assign w_rise     = irq & ~r_prev;
  assign w_elig     = r_pending & r_mask;
  assign w_ack_take = (r_state == REQ) && int_ack;
  // A rise on the same edge as the ack-clear must survive, so set is OR'ed after clear.
  assign w_clr      = w_ack_take ? src_onehot(r_active_src) : '0;
  assign w_vec      = PC_W'(VEC_BASE + VEC_STRIDE * 32'(w_idx));

  prio_enc4 u_prio_enc4 (
    .i_req   (w_elig),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_prev       <= irq;
      r_pending    <= '0;
      r_mask       <= '0;
      r_active_src <= SRC_TIMER;
      r_vector     <= PC_W'(VEC_BASE);
    end else begin
      r_prev    <= irq;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) r_mask <= mask_in;

      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_active_src <= w_idx;
            r_vector     <= w_vec;
            r_state      <= REQ;
          end
        end
        REQ: begin
          // Ack takes precedence over a mask that withdraws the request.
          if (int_ack)                     r_state <= SVC;
          else if (!r_mask[r_active_src])  r_state <= IDLE;
        end
        SVC: begin
          if (fin_int) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign int_req    = (r_state == REQ);
  assign pc_sel     = w_ack_take;
  assign in_service = (r_state == SVC);
  assign vector     = r_vector;
  assign active_src = r_active_src;
  assign pending    = r_pending;
  assign mask       = r_mask;

endmodule
